// File: rtl/tennis_pkg.sv
// Shared definitions for the tennis game button front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tennis_pkg;

   localparam int BTN_RESET = 0;
   localparam int BTN_P1    = 1;
   localparam int BTN_P2    = 2;
   localparam int BTN_COUNT = 3;

   typedef enum logic [1:0] {
      RST_IDLE   = 2'd0,
      RST_ARMING = 2'd1,
      RST_FIRED  = 2'd2
   } rst_state_t;

endpackage

// File: rtl/debounce_channel.sv
// Synchronises and debounces one raw button; emits a registered rise pulse.
// Latency: raw edge -> level change 2+DEBOUNCE_CYCLES, -> press one cycle later.
// Backpressure: none; press is a fire-and-forget single-cycle pulse.
module debounce_channel #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int DB_W            = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic            level_d;
   logic [DB_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         press   <= level & ~level_d;
         // Any cycle where the synced input agrees with the stable level restarts the run.
         if (sync2 != level) begin
            if (cnt == DB_LAST) begin
               level <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + DB_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounces reset/player buttons, masks presses during a reset hold, fires game_reset.
// Latency: press 3+DEBOUNCE_CYCLES after raw edge; game_reset HOLD_CYCLES after arming.
// Backpressure: none; all event outputs are single-cycle pulses.
module button_conditioner
   import tennis_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int DB_W            = 20,
   parameter int HOLD_W          = 26
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reset_button_raw,
   input  logic player1_raw,
   input  logic player2_raw,
   output logic p1_level,
   output logic p2_level,
   output logic p1_press,
   output logic p2_press,
   output logic reset_arming,
   output logic game_reset
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [BTN_COUNT-1:0] raw_vec;
   logic [BTN_COUNT-1:0] level_vec;
   logic [BTN_COUNT-1:0] rise_vec;
   logic                 rs;
   logic                 rs_rise_unused;

   rst_state_t        state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic              game_reset_nxt;

   assign raw_vec[BTN_RESET] = reset_button_raw;
   assign raw_vec[BTN_P1]    = player1_raw;
   assign raw_vec[BTN_P2]    = player2_raw;

   for (genvar g = 0; g < BTN_COUNT; g++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DB_W            (DB_W)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_vec[g]),
         .level (level_vec[g]),
         .press (rise_vec[g])
      );
   end

   assign rs             = level_vec[BTN_RESET];
   assign rs_rise_unused = rise_vec[BTN_RESET];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST_IDLE;
         hold_cnt   <= '0;
         game_reset <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_cnt_nxt;
         game_reset <= game_reset_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      hold_cnt_nxt   = hold_cnt;
      game_reset_nxt = 1'b0;
      case (state)
         RST_IDLE: begin
            if (rs) begin
               state_nxt    = RST_ARMING;
               hold_cnt_nxt = '0;
            end
         end
         RST_ARMING: begin
            // A release always wins, even on the terminal count.
            if (!rs) begin
               state_nxt = RST_IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               game_reset_nxt = 1'b1;
               state_nxt      = RST_FIRED;
            end else begin
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         RST_FIRED: begin
            if (!rs) state_nxt = RST_IDLE;
         end
         default: state_nxt = RST_IDLE;
      endcase
   end

   assign reset_arming = (state == RST_ARMING);
   assign p1_level     = level_vec[BTN_P1];
   assign p2_level     = level_vec[BTN_P2];
   assign p1_press     = rise_vec[BTN_P1] & (state == RST_IDLE);
   assign p2_press     = rise_vec[BTN_P2] & (state == RST_IDLE);

endmodule
